booth_mult_seq: RTL and testbench

- Parametrised sequential radix-4 Booth multiplier. Next generation of the fixed 4-bit combinational signed array multiplier.
- Adds configurable WIDTH, a runtime signed/unsigned mode, a start/ready handshake and overflow detection.
- Sits in the ALU multdiv path and trades latency (WIDTH/2+2 cycles) for roughly WIDTH/2 adders' worth of area.

---
 rtl/booth_mult_seq.sv | 132 +++++++++++++
 tb/tb_booth_mult_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier for the ALU multdiv path.
// Operands are widened by two bits, so a single signed datapath serves both signed and unsigned modes.
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ctrl_MULT,
  input  logic                 ctrl_signed,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  output logic [2*WIDTH-1:0]   result,
  output logic                 data_resultRDY,
  output logic                 data_exception,
  output logic                 busy
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = W2 / 2;
  localparam int CW = $clog2(N + 1);
  localparam int HW = W2 + 2;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [W2-1:0]     mcand_q;
  logic [W2-1:0]     mplier_q;
  logic              bm1_q;
  logic [HW-1:0]     acc_q;
  logic [CW-1:0]     cnt_q;
  logic              signed_q;
  logic              load;

  logic [W2-1:0]     ext_a, ext_b;
  logic [HW-1:0]     a_ext, a2, digit, sum;
  logic [2*WIDTH-1:0] prod;
  logic              exc_s, exc_u;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A new operation is accepted from IDLE or from DONE (back-to-back); RUN ignores requests.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        load    = ctrl_MULT;
        state_d = ctrl_MULT ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  assign ext_a = ctrl_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA} : {2'b00, data_operandA};
  assign ext_b = ctrl_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB} : {2'b00, data_operandB};

  assign a_ext = {{2{mcand_q[W2-1]}}, mcand_q};
  assign a2    = a_ext << 1;

  always_comb begin
    digit = '0;
    case ({mplier_q[1:0], bm1_q})
      3'b001, 3'b010: digit = a_ext;
      3'b011:         digit = a2;
      3'b100:         digit = -a2;
      3'b101, 3'b110: digit = -a_ext;
      default:        digit = '0;
    endcase
  end

  assign sum = acc_q + digit;

  // After N shifts the multiplier register holds the low W2 product bits and acc_q the rest.
  assign prod  = {acc_q[2*WIDTH-W2-1:0], mplier_q};
  assign exc_s = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  assign exc_u = |prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q        <= '0;
      mplier_q       <= '0;
      bm1_q          <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      signed_q       <= 1'b0;
      result         <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state_q == DONE) begin
        result         <= prod;
        data_exception <= signed_q ? exc_s : exc_u;
        data_resultRDY <= 1'b1;
      end
      if (load) begin
        mcand_q  <= ext_a;
        mplier_q <= ext_b;
        bm1_q    <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
        signed_q <= ctrl_signed;
      end else if (state_q == RUN) begin
        acc_q    <= {{2{sum[HW-1]}}, sum[HW-1:2]};
        mplier_q <= {sum[1:0], mplier_q[W2-1:2]};
        bm1_q    <= mplier_q[1];
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: a 4-bit and a 32-bit instance share clock and reset.
// Expected products come from plain integer arithmetic and are checked by per-instance monitors.
module tb_booth_mult_seq;

  localparam int N4  = 3;
  localparam int N32 = 17;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;

  logic        start4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  res4;
  logic        rdy4, exc4, busy4;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, exc32, busy32;

  typedef struct {
    logic [63:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q32[$];
  exp_t e4, e32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] last4 = '0, last32 = '0;
  logic        lastx4 = 1'b0, lastx32 = 1'b0;

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(start4), .ctrl_signed(sgn4),
    .data_operandA(a4), .data_operandB(b4), .result(res4),
    .data_resultRDY(rdy4), .data_exception(exc4), .busy(busy4)
  );

  booth_mult_seq #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(start32), .ctrl_signed(sgn32),
    .data_operandA(a32), .data_operandB(b32), .result(res32),
    .data_resultRDY(rdy32), .data_exception(exc32), .busy(busy32)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact product from integer arithmetic; the exception is a range check on that product.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [63:0] p, output logic e);
    longint sa, sb, pr;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa -= (longint'(1) << w);
    if (s && b[w-1]) sb -= (longint'(1) << w);
    pr   = sa * sb;
    mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    p    = 64'(pr) & mask;
    if (s) e = (pr < -(longint'(1) << (w - 1))) || (pr >= (longint'(1) << (w - 1)));
    else   e = ((64'(pr)) >> w) != 64'd0;
  endfunction

  // Monitors: each ready pulse must match the oldest expectation; otherwise outputs must hold.
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      last4  = '0;
      lastx4 = 1'b0;
    end else if (rdy4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rdy4_unexpected: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        e4 = q4.pop_front();
        checkOutput("res4", {56'd0, res4}, e4.res);
        checkOutput("exc4", {63'd0, exc4}, {63'd0, e4.exc});
        checkOutput("lat4", 64'(cyc), 64'(e4.cyc));
        last4  = e4.res;
        lastx4 = e4.exc;
      end
    end else begin
      checkOutput("hold_res4", {56'd0, res4}, last4);
      checkOutput("hold_exc4", {63'd0, exc4}, {63'd0, lastx4});
    end
  end

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      last32  = '0;
      lastx32 = 1'b0;
    end else if (rdy32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rdy32_unexpected: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        e32 = q32.pop_front();
        checkOutput("res32", res32, e32.res);
        checkOutput("exc32", {63'd0, exc32}, {63'd0, e32.exc});
        checkOutput("lat32", 64'(cyc), 64'(e32.cyc));
        last32  = e32.res;
        lastx32 = e32.exc;
      end
    end else begin
      checkOutput("hold_res32", res32, last32);
      checkOutput("hold_exc32", {63'd0, exc32}, {63'd0, lastx32});
    end
  end

  // Called just after a falling edge; the following rising edge accepts the request.
  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic s,
                                input logic [63:0] er, input logic ee);
    a4 = a;
    b4 = b;
    sgn4 = s;
    start4 = 1'b1;
    q4.push_back('{res: er, exc: ee, cyc: cyc + N4 + 2});
    @(negedge clock);
    start4 = 1'b0;
  endtask

  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic [63:0] er, input logic ee);
    a32 = a;
    b32 = b;
    sgn32 = s;
    start32 = 1'b1;
    q32.push_back('{res: er, exc: ee, cyc: cyc + N32 + 2});
    @(negedge clock);
    start32 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q4.size() != 0 || q32.size() != 0); i++) @(negedge clock);
    if (q4.size() != 0 || q32.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", q4.size() + q32.size());
      q4.delete();
      q32.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] p;
    logic        e;
    logic [3:0]  ra, rb;
    logic [31:0] ra32, rb32;
    logic        rs;

    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset_res4",  {56'd0, res4}, 64'd0);
    checkOutput("reset_rdy4",  {63'd0, rdy4}, 64'd0);
    checkOutput("reset_exc4",  {63'd0, exc4}, 64'd0);
    checkOutput("reset_busy4", {63'd0, busy4}, 64'd0);
    checkOutput("reset_res32", res32, 64'd0);
    checkOutput("reset_busy32", {63'd0, busy32}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    applyStimulus4(4'b1000, 4'b1000, 1'b1, 64'h40, 1'b1);
    checkOutput("busy4_run", {63'd0, busy4}, 64'd1);
    drain();
    applyStimulus4(4'd3, 4'b1110, 1'b1, 64'hFA, 1'b0);
    drain();
    applyStimulus4(4'd3, 4'b1110, 1'b0, 64'h2A, 1'b1);
    drain();
    applyStimulus4(4'd15, 4'd15, 1'b0, 64'hE1, 1'b1);
    drain();
    applyStimulus4(4'd3, 4'd5, 1'b0, 64'h0F, 1'b0);
    drain();
    applyStimulus32(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 1'b1);
    drain();

    // A second request during RUN must be ignored.
    applyStimulus4(4'd2, 4'd3, 1'b1, 64'h06, 1'b0);
    @(negedge clock);
    a4 = 4'd7;
    b4 = 4'd7;
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    drain();

    // Request presented in the DONE cycle is accepted back-to-back.
    applyStimulus4(4'd5, 4'd6, 1'b0, 64'h1E, 1'b1);
    repeat (N4) @(negedge clock);
    applyStimulus4(4'b1101, 4'd7, 1'b1, 64'hEB, 1'b1);
    drain();

    // Reset mid-RUN aborts with no ready pulse.
    a4 = 4'd6;
    b4 = 4'd7;
    sgn4 = 1'b0;
    start4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_res4",  {56'd0, res4}, 64'd0);
    checkOutput("abort_exc4",  {63'd0, exc4}, 64'd0);
    checkOutput("abort_busy4", {63'd0, busy4}, 64'd0);
    checkOutput("abort_rdy4",  {63'd0, rdy4}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (N4 + 3) @(negedge clock);
    applyStimulus4(4'hF, 4'hF, 1'b1, 64'h01, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      model(4, {28'd0, ra}, {28'd0, rb}, rs, p, e);
      applyStimulus4(ra, rb, rs, p, e);
      repeat ($urandom_range(N4, N4 + 2)) @(negedge clock);
    end
    drain();

    for (int i = 0; i < 20; i++) begin
      ra32 = $urandom();
      rb32 = $urandom();
      if (i == 0) begin
        ra32 = 32'h80000000;
        rb32 = 32'h80000000;
      end
      rs = 1'($urandom_range(0, 1));
      if (i == 0) rs = 1'b1;
      model(32, ra32, rb32, rs, p, e);
      applyStimulus32(ra32, rb32, rs, p, e);
      repeat ($urandom_range(N32, N32 + 2)) @(negedge clock);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
